cb_policy_engine: RTL and testbench
===================================

CB_POLICY_ENGINE -- requirements
Module: cb_policy_engine

Interface
REQ-001 Parameter CONF_MIN, default 16: minimum ml_confidence for an ML result to act (NORMAL excepted).
REQ-002 Parameter CONFIRM_N, default 2: consecutive qualifying results of one class needed to enter THROTTLE or WIDEN.
REQ-003 Parameter HOLDOFF, default 8: cycles after self-heal expiry during which only PAUSE may trip.
REQ-004 clk  in  1  single system clock, all state on rising edge.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 ml_valid  in  1  one-cycle strobe, ML result present.
REQ-007 ml_class  in  3  0 NORMAL, 3 FLASH_CRASH, 4 ORDER_IMBALANCE, 5 QUOTE_STUFFING; others unused.
REQ-008 ml_confidence  in  8  unsigned confidence.
REQ-009 host_clear  in  1  one-cycle host override forcing NORMAL.
REQ-010 cb_mode  out  2  00 NORMAL, 01 THROTTLE, 10 WIDEN, 11 PAUSE; registered, consumed by order_book.
REQ-011 cb_param  out  4  THROTTLE: throttle divisor; WIDEN: spread guard in book ticks; else 0.
REQ-012 cb_countdown  out  9  remaining cycles of active mode.
REQ-013 cb_active  out  1  high when cb_mode != NORMAL.
REQ-014 trip_cnt  out  8  count of entries into non-NORMAL modes (stats).

Function
REQ-015 Result sampled on ml_valid at edge t; resulting cb_mode/cb_param/cb_countdown visible after edge t (1-cycle latency), giving 2-cycle ML-to-order-book response.
REQ-016 Qualifying result: ml_valid=1, class in {3,4,5}, ml_confidence >= CONF_MIN; class 1,2,6,7 ignored, no state change, confirm counter untouched.
REQ-017 Class 3 trips PAUSE immediately (no confirmation); countdown = 2*confidence (9 bits, max 510).
REQ-018 Class 5 enters THROTTLE after CONFIRM_N consecutive qualifying class-5 results; cb_param = confidence>>4; countdown = 2*confidence.
REQ-019 Class 4 enters WIDEN after CONFIRM_N consecutive qualifying class-4 results; cb_param = confidence>>5 (zero-extended); countdown = 2*confidence.
REQ-020 Confirm counter resets on any qualifying result of a different class, on NORMAL, and on any mode change; it saturates at CONFIRM_N.
REQ-021 Severity PAUSE > THROTTLE > WIDEN; higher severity preempts active lower mode; lower-severity result during higher mode ignored.
REQ-022 Same-mode retrigger reloads countdown with max(current, new) and updates cb_param to new value.
REQ-023 Class 0 with ml_valid clears to NORMAL next cycle regardless of confidence; countdown 0, cb_param 0, no holdoff.
REQ-024 Countdown decrements by 1 each cycle while non-NORMAL; when it reaches 0 the block returns to NORMAL on that edge and starts HOLDOFF counter.
REQ-025 During HOLDOFF only class 3 can trip; class 4/5 results ignored and do not advance confirmation.
REQ-026 Confidence yielding countdown 0 (confidence 0) never trips.
REQ-027 host_clear has priority over a simultaneous ml_valid: result NORMAL, holdoff cleared, confirm counter cleared.
REQ-028 trip_cnt increments once per transition into a non-NORMAL mode, including preemption; saturates at 255.

Reset
REQ-029 On rst_n low, immediately: cb_mode=00, cb_param=0, cb_countdown=0, cb_active=0, trip_cnt=0, confirm and holdoff counters 0.
REQ-030 Reset asserted mid-countdown abandons the mode; no trip recorded on release.

Configuration
REQ-031 Macro CB_STATS_EN defined: trip_cnt logic per REQ-028 present.
REQ-032 CB_STATS_EN undefined: trip_cnt port retained, tied to 0, no counter flops.

Structure
REQ-033 Shared package nanotrade_pkg holds cb_mode encodings, ML class encodings and countdown width (9).
REQ-034 One sub-module cb_confirm_filter (class debounce + holdoff gating) is natural; mode FSM and countdown stay in top.

Verification
REQ-035 Reset; class 3 conf 60 -> next cycle cb_mode=11, countdown=120; after 120 more cycles cb_mode=00.
REQ-036 Class 5 conf 60 once -> cb_mode stays 00; second consecutive -> cb_mode=01, cb_param=3, countdown=120.
REQ-037 Class 4 conf 64 twice -> cb_mode=10, cb_param=2; then class 5 conf 64 twice -> cb_mode=01 (preempt); then class 4 -> unchanged.
REQ-038 PAUSE active, class 0 conf 0 -> cb_mode=00, cb_active=0 next cycle; class 3 conf 10 (< CONF_MIN) -> no trip.
REQ-039 Class 3 conf 10 with CONF_MIN=8 -> countdown 20, self-heals at 20; class 4 ×2 within 8 cycles ignored; class 3 within holdoff trips.
REQ-040 host_clear and class 3 conf 200 same cycle -> cb_mode=00; with CB_STATS_EN, 300 trips -> trip_cnt=255.

Source files
------------

// File: rtl/nanotrade_pkg.sv
// Shared encodings for the nanotrade circuit-breaker path: breaker modes,
// ML result classes and the countdown width.
package nanotrade_pkg;

  localparam int CD_W = 9;

  typedef enum logic [1:0] {
    CB_NORMAL   = 2'b00,
    CB_THROTTLE = 2'b01,
    CB_WIDEN    = 2'b10,
    CB_PAUSE    = 2'b11
  } cb_mode_e;

  typedef enum logic [2:0] {
    ML_NORMAL          = 3'd0,
    ML_FLASH_CRASH     = 3'd3,
    ML_ORDER_IMBALANCE = 3'd4,
    ML_QUOTE_STUFFING  = 3'd5
  } ml_class_e;

  // Mode encodings are not ordered by severity, so rank them explicitly.
  function automatic logic [1:0] cb_severity(input cb_mode_e m);
    case (m)
      CB_PAUSE:    cb_severity = 2'd3;
      CB_THROTTLE: cb_severity = 2'd2;
      CB_WIDEN:    cb_severity = 2'd1;
      default:     cb_severity = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/cb_confirm_filter.sv
// Debounces ML results: qualifies them, counts consecutive same-class hits for
// THROTTLE/WIDEN, and blocks those classes during the post-self-heal holdoff.
module cb_confirm_filter
  import nanotrade_pkg::*;
#(
  parameter int CONF_MIN  = 16,
  parameter int CONFIRM_N = 2,
  parameter int HOLDOFF   = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ml_valid,
  input  logic [2:0] ml_class,
  input  logic [7:0] ml_confidence,
  input  logic       host_clear,
  input  logic       mode_change,
  input  logic       heal,
  output logic       pause_hit,
  output logic       throttle_hit,
  output logic       widen_hit
);

  localparam int CW = $clog2(CONFIRM_N + 2);
  localparam int HW = $clog2(HOLDOFF + 2);
  localparam logic [CW-1:0] CNT_MAX   = CW'(CONFIRM_N);
  localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLDOFF);
  localparam logic [7:0]    CONF_MIN_L = 8'(CONF_MIN);

  logic [CW-1:0] cnt_q, cnt_inc;
  logic [2:0]    cls_q;
  logic [HW-1:0] hold_q;
  logic          qual, is_pause, is_debounced, hold_active, confirmed;

  always_comb begin
    // Confidence 0 maps to a zero countdown, so it can never qualify.
    qual         = ml_valid && (ml_confidence >= CONF_MIN_L) && (ml_confidence != 8'd0);
    is_pause     = qual && (ml_class == ML_FLASH_CRASH);
    hold_active  = (hold_q != '0);
    is_debounced = qual && !hold_active &&
                   ((ml_class == ML_ORDER_IMBALANCE) || (ml_class == ML_QUOTE_STUFFING));
    if ((cnt_q != '0) && (ml_class == cls_q))
      cnt_inc = (cnt_q >= CNT_MAX) ? cnt_q : cnt_q + 1'b1;
    else
      cnt_inc = CW'(1);
    confirmed    = is_debounced && (cnt_inc >= CNT_MAX);
    pause_hit    = is_pause;
    throttle_hit = confirmed && (ml_class == ML_QUOTE_STUFFING);
    widen_hit    = confirmed && (ml_class == ML_ORDER_IMBALANCE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      cls_q  <= ML_NORMAL;
      hold_q <= '0;
    end else begin
      if (host_clear || mode_change || (ml_valid && (ml_class == ML_NORMAL)) || is_pause) begin
        cnt_q <= '0;
      end else if (is_debounced) begin
        cnt_q <= cnt_inc;
        cls_q <= ml_class;
      end

      if (host_clear)       hold_q <= '0;
      else if (heal)        hold_q <= HOLD_LOAD;
      else if (hold_active) hold_q <= hold_q - 1'b1;
    end
  end

endmodule

// File: rtl/cb_policy_engine.sv
// Circuit-breaker mode FSM and countdown driven by ML anomaly results.
// Optional trip statistics counter enabled by defining CB_STATS_EN.
module cb_policy_engine
  import nanotrade_pkg::*;
#(
  parameter int CONF_MIN  = 16,
  parameter int CONFIRM_N = 2,
  parameter int HOLDOFF   = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ml_valid,
  input  logic [2:0]      ml_class,
  input  logic [7:0]      ml_confidence,
  input  logic            host_clear,
  output logic [1:0]      cb_mode,
  output logic [3:0]      cb_param,
  output logic [CD_W-1:0] cb_countdown,
  output logic            cb_active,
  output logic [7:0]      trip_cnt
);

  cb_mode_e        mode_q, mode_d, req_mode;
  logic [3:0]      param_q, param_d, req_param;
  logic [CD_W-1:0] cd_q, cd_d, cd_new;
  logic            req_valid, heal, mode_change;
  logic            pause_hit, throttle_hit, widen_hit;

  cb_confirm_filter #(
    .CONF_MIN  (CONF_MIN),
    .CONFIRM_N (CONFIRM_N),
    .HOLDOFF   (HOLDOFF)
  ) u_filter (
    .clk           (clk),
    .rst_n         (rst_n),
    .ml_valid      (ml_valid),
    .ml_class      (ml_class),
    .ml_confidence (ml_confidence),
    .host_clear    (host_clear),
    .mode_change   (mode_change),
    .heal          (heal),
    .pause_hit     (pause_hit),
    .throttle_hit  (throttle_hit),
    .widen_hit     (widen_hit)
  );

  always_comb begin
    cd_new    = {ml_confidence, 1'b0};
    req_valid = pause_hit || throttle_hit || widen_hit;
    req_mode  = CB_NORMAL;
    req_param = 4'd0;
    if (pause_hit) begin
      req_mode = CB_PAUSE;
    end else if (throttle_hit) begin
      req_mode  = CB_THROTTLE;
      req_param = ml_confidence[7:4];
    end else if (widen_hit) begin
      req_mode  = CB_WIDEN;
      req_param = {1'b0, ml_confidence[7:5]};
    end

    mode_d  = mode_q;
    param_d = param_q;
    cd_d    = cd_q;
    heal    = 1'b0;
    if (host_clear || (ml_valid && (ml_class == ML_NORMAL))) begin
      mode_d  = CB_NORMAL;
      param_d = 4'd0;
      cd_d    = '0;
    end else if (req_valid && (cb_severity(req_mode) > cb_severity(mode_q))) begin
      mode_d  = req_mode;
      param_d = req_param;
      cd_d    = cd_new;
    end else if (req_valid && (req_mode == mode_q)) begin
      param_d = req_param;
      cd_d    = (cd_new > cd_q) ? cd_new : cd_q;
    end else if (mode_q != CB_NORMAL) begin
      // Self-heal on the edge the countdown reaches zero; this arms the holdoff.
      if (cd_q <= CD_W'(1)) begin
        mode_d  = CB_NORMAL;
        param_d = 4'd0;
        cd_d    = '0;
        heal    = 1'b1;
      end else begin
        cd_d = cd_q - 1'b1;
      end
    end
    mode_change = (mode_d != mode_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q  <= CB_NORMAL;
      param_q <= 4'd0;
      cd_q    <= '0;
    end else begin
      mode_q  <= mode_d;
      param_q <= param_d;
      cd_q    <= cd_d;
    end
  end

  assign cb_mode      = mode_q;
  assign cb_param     = param_q;
  assign cb_countdown = cd_q;
  assign cb_active    = (mode_q != CB_NORMAL);

`ifdef CB_STATS_EN
  logic [7:0] trip_q;
  logic       trip;

  // Preemption counts as a new trip; a same-mode retrigger does not.
  assign trip = mode_change && (mode_d != CB_NORMAL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                         trip_q <= 8'd0;
    else if (trip && (trip_q != 8'hFF)) trip_q <= trip_q + 8'd1;
  end

  assign trip_cnt = trip_q;
`else
  assign trip_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_cb_policy_engine.sv
// Directed bench for cb_policy_engine: a default-parameter instance and a
// CONF_MIN=8 instance share one stimulus stream.
module tb_cb_policy_engine;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ml_valid = 1'b0;
  logic [2:0] ml_class = 3'd0;
  logic [7:0] ml_confidence = 8'd0;
  logic       host_clear = 1'b0;

  logic [1:0] cb_mode, b_mode;
  logic [3:0] cb_param, b_param;
  logic [8:0] cb_countdown, b_countdown;
  logic       cb_active, b_active;
  logic [7:0] trip_cnt, b_trip;

  int tests = 0;
  int failed = 0;

`ifdef CB_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  always #5 clk = ~clk;

  cb_policy_engine dut (
    .clk(clk), .rst_n(rst_n), .ml_valid(ml_valid), .ml_class(ml_class),
    .ml_confidence(ml_confidence), .host_clear(host_clear),
    .cb_mode(cb_mode), .cb_param(cb_param), .cb_countdown(cb_countdown),
    .cb_active(cb_active), .trip_cnt(trip_cnt)
  );

  cb_policy_engine #(.CONF_MIN(8)) dut_b (
    .clk(clk), .rst_n(rst_n), .ml_valid(ml_valid), .ml_class(ml_class),
    .ml_confidence(ml_confidence), .host_clear(host_clear),
    .cb_mode(b_mode), .cb_param(b_param), .cb_countdown(b_countdown),
    .cb_active(b_active), .trip_cnt(b_trip)
  );

  // Every task starts and ends at a falling edge and consumes whole cycles.
  task automatic send(input logic [2:0] cls, input logic [7:0] conf);
    ml_valid = 1'b1; ml_class = cls; ml_confidence = conf;
    @(negedge clk);
    ml_valid = 1'b0; ml_class = 3'd0; ml_confidence = 8'd0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic hclear();
    host_clear = 1'b1;
    @(negedge clk);
    host_clear = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle(3);
    tests++; if (cb_mode !== 2'b00) begin failed++; $display("FAIL reset_mode: got %0d want 0", cb_mode); end
    tests++; if (cb_param !== 4'd0) begin failed++; $display("FAIL reset_param: got %0d want 0", cb_param); end
    tests++; if (cb_countdown !== 9'd0) begin failed++; $display("FAIL reset_cd: got %0d want 0", cb_countdown); end
    tests++; if (cb_active !== 1'b0) begin failed++; $display("FAIL reset_active: got %0d want 0", cb_active); end
    tests++; if (trip_cnt !== 8'd0 || b_trip !== 8'd0) begin failed++; $display("FAIL reset_trip: got %0d/%0d want 0", trip_cnt, b_trip); end
    rst_n = 1'b1;
    idle(2);
  endtask

  task automatic test_pause();
    send(3'd3, 8'd60);
    tests++; if (cb_mode !== 2'b11) begin failed++; $display("FAIL pause_mode: got %0d want 3", cb_mode); end
    tests++; if (cb_countdown !== 9'd120) begin failed++; $display("FAIL pause_cd: got %0d want 120", cb_countdown); end
    tests++; if (cb_param !== 4'd0 || cb_active !== 1'b1) begin failed++; $display("FAIL pause_param_active: got %0d/%0d want 0/1", cb_param, cb_active); end
    idle(119);
    tests++; if (cb_mode !== 2'b11 || cb_countdown !== 9'd1) begin failed++; $display("FAIL pause_last: got mode %0d cd %0d want 3/1", cb_mode, cb_countdown); end
    idle(1);
    tests++; if (cb_mode !== 2'b00 || cb_countdown !== 9'd0) begin failed++; $display("FAIL pause_heal: got mode %0d cd %0d want 0/0", cb_mode, cb_countdown); end
    idle(10);
    send(3'd3, 8'd255);
    tests++; if (cb_countdown !== 9'd510) begin failed++; $display("FAIL pause_cd_max: got %0d want 510", cb_countdown); end
    send(3'd0, 8'd0);
  endtask

  task automatic test_throttle();
    send(3'd5, 8'd60);
    tests++; if (cb_mode !== 2'b00) begin failed++; $display("FAIL thr_first: got %0d want 0", cb_mode); end
    send(3'd5, 8'd60);
    tests++; if (cb_mode !== 2'b01 || cb_param !== 4'd3 || cb_countdown !== 9'd120) begin failed++; $display("FAIL thr_enter: got %0d/%0d/%0d want 1/3/120", cb_mode, cb_param, cb_countdown); end
    send(3'd5, 8'd60);
    tests++; if (cb_mode !== 2'b01 || cb_countdown !== 9'd119) begin failed++; $display("FAIL thr_unconfirmed: got %0d/%0d want 1/119", cb_mode, cb_countdown); end
    send(3'd5, 8'd100);
    tests++; if (cb_param !== 4'd6 || cb_countdown !== 9'd200) begin failed++; $display("FAIL thr_retrig_up: got %0d/%0d want 6/200", cb_param, cb_countdown); end
    send(3'd5, 8'd20);
    tests++; if (cb_param !== 4'd1 || cb_countdown !== 9'd200) begin failed++; $display("FAIL thr_retrig_keep: got %0d/%0d want 1/200", cb_param, cb_countdown); end
    send(3'd0, 8'd0);
    tests++; if (cb_mode !== 2'b00 || cb_param !== 4'd0 || cb_countdown !== 9'd0) begin failed++; $display("FAIL thr_clear: got %0d/%0d/%0d want 0/0/0", cb_mode, cb_param, cb_countdown); end
  endtask

  task automatic test_preempt();
    send(3'd4, 8'd64);
    send(3'd4, 8'd64);
    tests++; if (cb_mode !== 2'b10 || cb_param !== 4'd2 || cb_countdown !== 9'd128) begin failed++; $display("FAIL widen_enter: got %0d/%0d/%0d want 2/2/128", cb_mode, cb_param, cb_countdown); end
    send(3'd5, 8'd64);
    tests++; if (cb_mode !== 2'b10 || cb_countdown !== 9'd127) begin failed++; $display("FAIL widen_hold: got %0d/%0d want 2/127", cb_mode, cb_countdown); end
    send(3'd5, 8'd64);
    tests++; if (cb_mode !== 2'b01 || cb_param !== 4'd4 || cb_countdown !== 9'd128) begin failed++; $display("FAIL thr_preempt: got %0d/%0d/%0d want 1/4/128", cb_mode, cb_param, cb_countdown); end
    send(3'd4, 8'd64);
    send(3'd4, 8'd64);
    tests++; if (cb_mode !== 2'b01 || cb_param !== 4'd4 || cb_countdown !== 9'd126) begin failed++; $display("FAIL widen_ignored: got %0d/%0d/%0d want 1/4/126", cb_mode, cb_param, cb_countdown); end
    send(3'd3, 8'd50);
    tests++; if (cb_mode !== 2'b11 || cb_param !== 4'd0 || cb_countdown !== 9'd100) begin failed++; $display("FAIL pause_preempt: got %0d/%0d/%0d want 3/0/100", cb_mode, cb_param, cb_countdown); end
    send(3'd5, 8'd64);
    send(3'd5, 8'd64);
    tests++; if (cb_mode !== 2'b11 || cb_countdown !== 9'd98) begin failed++; $display("FAIL thr_under_pause: got %0d/%0d want 3/98", cb_mode, cb_countdown); end
    send(3'd0, 8'd0);
  endtask

  task automatic test_clear_and_qualify();
    send(3'd3, 8'd60);
    send(3'd0, 8'd0);
    tests++; if (cb_mode !== 2'b00 || cb_active !== 1'b0 || cb_countdown !== 9'd0) begin failed++; $display("FAIL class0_clear: got %0d/%0d/%0d want 0/0/0", cb_mode, cb_active, cb_countdown); end
    send(3'd3, 8'd10);
    tests++; if (cb_mode !== 2'b00) begin failed++; $display("FAIL below_conf_min: got %0d want 0", cb_mode); end
    send(3'd1, 8'd200);
    tests++; if (cb_mode !== 2'b00) begin failed++; $display("FAIL unused_class: got %0d want 0", cb_mode); end
    send(3'd5, 8'd60);
    send(3'd1, 8'd200);
    send(3'd5, 8'd60);
    tests++; if (cb_mode !== 2'b01) begin failed++; $display("FAIL unused_keeps_count: got %0d want 1", cb_mode); end
    send(3'd0, 8'd0);
    send(3'd5, 8'd60);
    send(3'd4, 8'd60);
    send(3'd5, 8'd60);
    tests++; if (cb_mode !== 2'b00) begin failed++; $display("FAIL other_class_resets: got %0d want 0", cb_mode); end
    send(3'd0, 8'd0);
  endtask

  task automatic test_holdoff();
    hclear();
    send(3'd3, 8'd10);
    tests++; if (b_mode !== 2'b11 || b_countdown !== 9'd20 || cb_mode !== 2'b00) begin failed++; $display("FAIL ho_trip: got b %0d/%0d a %0d want 3/20/0", b_mode, b_countdown, cb_mode); end
    idle(20);
    tests++; if (b_mode !== 2'b00 || b_active !== 1'b0) begin failed++; $display("FAIL ho_heal: got %0d/%0d want 0/0", b_mode, b_active); end
    send(3'd4, 8'd64);
    send(3'd4, 8'd64);
    tests++; if (b_mode !== 2'b00) begin failed++; $display("FAIL ho_widen_blocked: got %0d want 0", b_mode); end
    send(3'd3, 8'd10);
    tests++; if (b_mode !== 2'b11 || b_countdown !== 9'd20) begin failed++; $display("FAIL ho_pause_allowed: got %0d/%0d want 3/20", b_mode, b_countdown); end
    send(3'd0, 8'd0);
    idle(10);
    send(3'd4, 8'd64);
    send(3'd4, 8'd64);
    tests++; if (b_mode !== 2'b10 || b_param !== 4'd2 || b_countdown !== 9'd128) begin failed++; $display("FAIL ho_after_widen: got %0d/%0d/%0d want 2/2/128", b_mode, b_param, b_countdown); end
    send(3'd0, 8'd0);
  endtask

  task automatic test_host_clear();
    send(3'd3, 8'd60);
    host_clear = 1'b1; ml_valid = 1'b1; ml_class = 3'd3; ml_confidence = 8'd200;
    @(negedge clk);
    host_clear = 1'b0; ml_valid = 1'b0; ml_class = 3'd0; ml_confidence = 8'd0;
    tests++; if (cb_mode !== 2'b00 || cb_countdown !== 9'd0 || cb_active !== 1'b0) begin failed++; $display("FAIL hc_priority: got %0d/%0d/%0d want 0/0/0", cb_mode, cb_countdown, cb_active); end
    send(3'd5, 8'd60);
    hclear();
    send(3'd5, 8'd60);
    tests++; if (cb_mode !== 2'b00) begin failed++; $display("FAIL hc_confirm_cleared: got %0d want 0", cb_mode); end
    send(3'd5, 8'd60);
    tests++; if (cb_mode !== 2'b01) begin failed++; $display("FAIL hc_then_confirm: got %0d want 1", cb_mode); end
    send(3'd0, 8'd0);
    send(3'd3, 8'd16);
    idle(32);
    hclear();
    send(3'd5, 8'd60);
    send(3'd5, 8'd60);
    tests++; if (cb_mode !== 2'b01 || cb_param !== 4'd3) begin failed++; $display("FAIL hc_holdoff_cleared: got %0d/%0d want 1/3", cb_mode, cb_param); end
    send(3'd0, 8'd0);
  endtask

  task automatic test_reset_mid();
    send(3'd3, 8'd60);
    #2 rst_n = 1'b0;
    #1;
    tests++; if (cb_mode !== 2'b00 || cb_countdown !== 9'd0 || cb_active !== 1'b0) begin failed++; $display("FAIL async_reset: got %0d/%0d/%0d want 0/0/0", cb_mode, cb_countdown, cb_active); end
    @(negedge clk);
    rst_n = 1'b1;
    idle(3);
    tests++; if (cb_mode !== 2'b00 || trip_cnt !== 8'd0) begin failed++; $display("FAIL reset_release: got %0d/%0d want 0/0", cb_mode, trip_cnt); end
  endtask

  task automatic test_stats();
    logic [7:0] exp3, exp_sat;
    exp3    = STATS ? 8'd3 : 8'd0;
    exp_sat = STATS ? 8'd255 : 8'd0;
    for (int i = 0; i < 300; i++) begin
      send(3'd3, 8'd100);
      send(3'd0, 8'd0);
      if (i == 2) begin
        tests++; if (trip_cnt !== exp3) begin failed++; $display("FAIL trip_cnt_3: got %0d want %0d", trip_cnt, exp3); end
      end
    end
    tests++; if (trip_cnt !== exp_sat) begin failed++; $display("FAIL trip_cnt_sat: got %0d want %0d", trip_cnt, exp_sat); end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_pause();
    test_throttle();
    test_preempt();
    test_clear_and_qualify();
    test_holdoff();
    test_host_clear();
    test_reset_mid();
    test_stats();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
